// File: rtl/baccarat_pkg.sv
// Shared baccarat definitions: deal-order checker states,
// card values, score constants and the controller's result codes.
package baccarat_pkg;

    localparam logic [3:0] RANK_EMPTY = 4'd0;
    localparam int SCORE_MOD = 10;
    localparam int NATURAL_MIN = 8;

    typedef enum logic [2:0] {
        EXP_P1,
        EXP_D1,
        EXP_P2,
        EXP_D2,
        OPT3,
        DONE
    } chk_state_t;

    typedef enum logic [1:0] {
        RESULT_NONE,
        RESULT_PLAYER,
        RESULT_DEALER,
        RESULT_TIE
    } result_t;

    // Ten and face cards count zero, as does an empty slot.
    function automatic logic [3:0] card_value(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd9) ? r : 4'd0;
    endfunction

endpackage

// File: rtl/card_score.sv
// Three-card hand score: sum of card values mod 10.
// Ports: r1, r2, r3 (4-bit ranks) in; score (0..9) out.
module card_score
    import baccarat_pkg::*;
(
    input  logic [3:0] r1,
    input  logic [3:0] r2,
    input  logic [3:0] r3,
    output logic [3:0] score
);

    localparam logic [4:0] MOD1 = 5'(SCORE_MOD);
    localparam logic [4:0] MOD2 = 5'(2 * SCORE_MOD);

    logic [4:0] sum;

    assign sum = {1'b0, card_value(r1)}
               + {1'b0, card_value(r2)}
               + {1'b0, card_value(r3)};

    // Sum never exceeds 27, so at most two subtractions.
    always_comb begin
        if (sum >= MOD2)
            score = 4'(sum - MOD2);
        else if (sum >= MOD1)
            score = 4'(sum - MOD1);
        else
            score = sum[3:0];
    end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat datapath: dealer counter, six card slots, scores and a
// deal-order checker that flags illegal load sequences.
// Ports: slow_clock, reset (sync, active high), six load strobes in;
// six card ranks, pcard3 value, pscore, dscore, cards_dealt,
// protocol_error out.
module baccarat_datapath
    import baccarat_pkg::*;
#(
    parameter int NUM_RANKS  = 13,
    parameter int START_RANK = 1
)
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1_rank,
    output logic [3:0] pcard2_rank,
    output logic [3:0] pcard3_rank,
    output logic [3:0] dcard1_rank,
    output logic [3:0] dcard2_rank,
    output logic [3:0] dcard3_rank,
    output logic [3:0] pcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic       protocol_error
);

    localparam logic [3:0] LAST  = 4'(NUM_RANKS);
    localparam logic [3:0] FIRST = 4'(START_RANK);

    logic [3:0] deal_q;
    logic [3:0] rank_q [6];
    logic [5:0] ld;
    chk_state_t st_q, st_d;
    logic       p3_q, p3_d;
    logic       ok;
    logic       bad_evt;

    // Slot order: p1, p2, p3, d1, d2, d3.
    assign ld = {load_dcard3, load_dcard2, load_dcard1,
                 load_pcard3, load_pcard2, load_pcard1};

    always_comb begin
        ok   = 1'b0;
        st_d = st_q;
        p3_d = p3_q;
        if ($onehot(ld)) begin
            unique case (st_q)
                EXP_P1: if (ld[0]) begin
                    ok   = 1'b1;
                    st_d = EXP_D1;
                end
                EXP_D1: if (ld[3]) begin
                    ok   = 1'b1;
                    st_d = EXP_P2;
                end
                EXP_P2: if (ld[1]) begin
                    ok   = 1'b1;
                    st_d = EXP_D2;
                end
                EXP_D2: if (ld[4]) begin
                    ok   = 1'b1;
                    st_d = OPT3;
                end
                OPT3: begin
                    if (ld[2] && !p3_q) begin
                        ok   = 1'b1;
                        p3_d = 1'b1;
                    end else if (ld[5]) begin
                        ok   = 1'b1;
                        st_d = DONE;
                    end
                end
                default: ok = 1'b0;
            endcase
        end
    end

    assign bad_evt = (|ld) && !ok;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            deal_q         <= FIRST;
            st_q           <= EXP_P1;
            p3_q           <= 1'b0;
            cards_dealt    <= 3'd0;
            protocol_error <= 1'b0;
            for (int i = 0; i < 6; i++)
                rank_q[i] <= RANK_EMPTY;
        end else begin
            deal_q <= (deal_q == LAST) ? 4'd1 : deal_q + 4'd1;
            if (ok) begin
                for (int i = 0; i < 6; i++)
                    if (ld[i])
                        rank_q[i] <= deal_q;
                st_q <= st_d;
                p3_q <= p3_d;
                if (cards_dealt != 3'd6)
                    cards_dealt <= cards_dealt + 3'd1;
            end
            if (bad_evt)
                protocol_error <= 1'b1;
        end
    end

    assign pcard1_rank = rank_q[0];
    assign pcard2_rank = rank_q[1];
    assign pcard3_rank = rank_q[2];
    assign dcard1_rank = rank_q[3];
    assign dcard2_rank = rank_q[4];
    assign dcard3_rank = rank_q[5];
    assign pcard3      = card_value(rank_q[2]);

    card_score u_pscore (
        .r1    (rank_q[0]),
        .r2    (rank_q[1]),
        .r3    (rank_q[2]),
        .score (pscore)
    );

    card_score u_dscore (
        .r1    (rank_q[3]),
        .r2    (rank_q[4]),
        .r3    (rank_q[5]),
        .score (dscore)
    );

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: directed hands plus random strobes
// compared against a rule-level model of the game.
module tb_baccarat_datapath;

    logic       slow_clock;
    logic       reset;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard1_rank, pcard2_rank, pcard3_rank;
    logic [3:0] dcard1_rank, dcard2_rank, dcard3_rank;
    logic [3:0] pcard3, pscore, dscore;
    logic [2:0] cards_dealt;
    logic       protocol_error;

    int total = 0;
    int bad   = 0;

    // Model: slots 0..2 player, 3..5 dealer.
    int m_ctr;
    int m_dealt;
    int rk [6];
    bit m_p3, m_done, m_err;
    int seq [4] = '{0, 3, 1, 4};

    baccarat_datapath dut (
        .slow_clock     (slow_clock),
        .reset          (reset),
        .load_pcard1    (load_pcard1),
        .load_pcard2    (load_pcard2),
        .load_pcard3    (load_pcard3),
        .load_dcard1    (load_dcard1),
        .load_dcard2    (load_dcard2),
        .load_dcard3    (load_dcard3),
        .pcard1_rank    (pcard1_rank),
        .pcard2_rank    (pcard2_rank),
        .pcard3_rank    (pcard3_rank),
        .dcard1_rank    (dcard1_rank),
        .dcard2_rank    (dcard2_rank),
        .dcard3_rank    (dcard3_rank),
        .pcard3         (pcard3),
        .pscore         (pscore),
        .dscore         (dscore),
        .cards_dealt    (cards_dealt),
        .protocol_error (protocol_error)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    function automatic int val(input int r);
        return (r >= 1 && r <= 9) ? r : 0;
    endfunction

    function automatic bit legal(input int s);
        if (m_dealt < 4) return s == seq[m_dealt];
        if (m_done) return 1'b0;
        if (s == 5) return 1'b1;
        return (s == 2) && !m_p3;
    endfunction

    function automatic int next_legal();
        for (int s = 0; s < 6; s++)
            if (legal(s)) return s;
        return -1;
    endfunction

    task automatic model_edge(input logic [5:0] ld, input bit rst);
        int n;
        int s;
        if (rst) begin
            m_ctr = 1;
            m_dealt = 0;
            m_p3 = 0;
            m_done = 0;
            m_err = 0;
            for (int i = 0; i < 6; i++) rk[i] = 0;
            return;
        end
        n = $countones(ld);
        s = -1;
        for (int i = 0; i < 6; i++) if (ld[i]) s = i;
        if (n > 1) m_err = 1;
        else if (n == 1) begin
            if (legal(s)) begin
                rk[s] = m_ctr;
                if (s == 2) m_p3 = 1;
                if (s == 5) m_done = 1;
                if (m_dealt < 6) m_dealt++;
            end else m_err = 1;
        end
        m_ctr = (m_ctr == 13) ? 1 : m_ctr + 1;
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ps, ds;
        ps = (val(rk[0]) + val(rk[1]) + val(rk[2])) % 10;
        ds = (val(rk[3]) + val(rk[4]) + val(rk[5])) % 10;
        chk("pcard1_rank", {4'd0, pcard1_rank}, 8'(rk[0]));
        chk("pcard2_rank", {4'd0, pcard2_rank}, 8'(rk[1]));
        chk("pcard3_rank", {4'd0, pcard3_rank}, 8'(rk[2]));
        chk("dcard1_rank", {4'd0, dcard1_rank}, 8'(rk[3]));
        chk("dcard2_rank", {4'd0, dcard2_rank}, 8'(rk[4]));
        chk("dcard3_rank", {4'd0, dcard3_rank}, 8'(rk[5]));
        chk("pcard3", {4'd0, pcard3}, 8'(val(rk[2])));
        chk("pscore", {4'd0, pscore}, 8'(ps));
        chk("dscore", {4'd0, dscore}, 8'(ds));
        chk("cards_dealt", {5'd0, cards_dealt}, 8'(m_dealt));
        chk("protocol_error", {7'd0, protocol_error}, 8'(m_err));
    endtask

    task automatic step(input logic [5:0] ld, input bit rst);
        {load_dcard3, load_dcard2, load_dcard1,
         load_pcard3, load_pcard2, load_pcard1} = ld;
        reset = rst;
        @(posedge slow_clock);
        model_edge(ld, rst);
        #1;
        {load_dcard3, load_dcard2, load_dcard1,
         load_pcard3, load_pcard2, load_pcard1} = 6'd0;
        reset = 1'b0;
        check_all();
    endtask

    // Idle until the dealer shows the wanted rank, then load a slot.
    task automatic deal_at(input int s, input int r);
        for (int k = 0; k < 13 && m_ctr != r; k++)
            step(6'd0, 1'b0);
        step(6'(1 << s), 1'b0);
    endtask

    initial begin
        int rr;
        int s;
        logic [5:0] ld;
        bit rst;
        reset = 1'b1;
        {load_dcard3, load_dcard2, load_dcard1,
         load_pcard3, load_pcard2, load_pcard1} = 6'd0;
        #1;

        // Reset, then first card and a full four-card deal.
        step(6'd0, 1'b1);
        step(6'b000001, 1'b0);
        step(6'b001000, 1'b0);
        step(6'b000010, 1'b0);
        step(6'b010000, 1'b0);
        step(6'b000100, 1'b0);
        step(6'b000100, 1'b0);
        step(6'b100000, 1'b0);
        step(6'b000001, 1'b0);

        // Face cards and wrap.
        step(6'd0, 1'b1);
        deal_at(0, 9);
        deal_at(3, 12);
        deal_at(1, 10);
        deal_at(4, 1);
        deal_at(2, 13);
        deal_at(5, 5);

        // Mod-10 reduction.
        step(6'd0, 1'b1);
        deal_at(0, 7);
        deal_at(3, 3);
        deal_at(1, 8);
        deal_at(4, 6);
        deal_at(2, 9);
        deal_at(5, 9);

        // Protocol errors stay sticky until reset.
        step(6'd0, 1'b1);
        step(6'b001000, 1'b0);
        step(6'd0, 1'b0);
        step(6'b000001, 1'b0);
        step(6'd0, 1'b1);
        step(6'b001001, 1'b0);
        step(6'd0, 1'b0);

        // Mid-hand reset, and reset beating a load.
        step(6'd0, 1'b1);
        step(6'b000001, 1'b0);
        step(6'b001000, 1'b0);
        step(6'b000010, 1'b0);
        step(6'd0, 1'b1);
        step(6'b000001, 1'b1);
        step(6'b000001, 1'b0);

        for (int i = 0; i < 500; i++) begin
            rr = int'($urandom_range(0, 19));
            rst = 1'b0;
            ld = 6'd0;
            if (rr == 0) begin
                rst = 1'b1;
                ld = 6'($urandom_range(0, 63));
            end else if (rr < 6) begin
                ld = 6'd0;
            end else if (rr < 14) begin
                s = next_legal();
                if (s >= 0) ld = 6'(1 << s);
            end else if (rr < 18) begin
                ld = 6'(1 << $urandom_range(0, 5));
            end else begin
                ld = 6'($urandom_range(0, 63));
            end
            step(ld, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
